// File: rtl/vicii_pkg.sv
// Shared VIC-II constants: colour width, sprite count limit and the
// collision register addresses.
package vicii_pkg;
  localparam int COLOR_W = 4;
  localparam int MAX_SPR = 8;
  localparam logic [5:0] REG_MM = 6'h1E;
  localparam logic [5:0] REG_MD = 6'h1F;

  // Nonzero when at least two bits of v are set.
  function automatic logic multi_hot(input logic [MAX_SPR-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction
endpackage

// File: rtl/vicii_sprite_prio_enc.sv
// Combinational priority encoder: the lowest set request bit wins.
module vicii_sprite_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Scan high to low so the lowest index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vicii_sprite_mux.sv
// Sprite/background pixel mux with sprite-sprite and sprite-data collision
// registers; collision logic present only with VICII_SPRITE_COLLISION_EN.
module vicii_sprite_mux
  import vicii_pkg::*;
#(
  parameter int NSPR = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSPR-1:0]         spr_en,
  input  logic [COLOR_W*NSPR-1:0] spr_pix,
  input  logic [COLOR_W-1:0]      bg_pix,
  input  logic                    bg_fg,
  input  logic [MAX_SPR-1:0]      MDP,
  input  logic                    pix_valid,
  input  logic                    rd_mm,
  input  logic                    rd_md,
  output logic [COLOR_W-1:0]      pixel,
  output logic [MAX_SPR-1:0]      MM,
  output logic [MAX_SPR-1:0]      MD,
  output logic                    irq_mm,
  output logic                    irq_md
);
  logic [COLOR_W-1:0] spr_col [NSPR];
  logic [2:0]         win_idx;
  logic               win_vld;
  logic [COLOR_W-1:0] next_pix;

  for (genvar n = 0; n < NSPR; n++) begin : g_col
    assign spr_col[n] = spr_pix[n*COLOR_W +: COLOR_W];
  end

  vicii_sprite_prio_enc #(.N(NSPR)) u_prio (
    .req (spr_en),
    .idx (win_idx),
    .vld (win_vld)
  );

  // Only the winner's MDP bit matters; lower sprites never show through.
  always_comb begin
    next_pix = bg_pix;
    if (win_vld && !(MDP[win_idx] && bg_fg))
      next_pix = spr_col[win_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pixel <= '0;
    else       pixel <= next_pix;
  end

`ifdef VICII_SPRITE_COLLISION_EN
  logic [MAX_SPR-1:0] en8, new_mm, new_md, mm_base, md_base;

  always_comb begin
    en8               = '0;
    en8[NSPR-1:0]     = spr_en;
    new_mm            = (pix_valid && multi_hot(en8)) ? en8 : '0;
    new_md            = (pix_valid && bg_fg) ? en8 : '0;
    // A read clears the old value but same-cycle collisions still land.
    mm_base           = rd_mm ? '0 : MM;
    md_base           = rd_md ? '0 : MD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MM     <= '0;
      MD     <= '0;
      irq_mm <= 1'b0;
      irq_md <= 1'b0;
    end else begin
      MM     <= mm_base | new_mm;
      MD     <= md_base | new_md;
      irq_mm <= (new_mm != '0) && (mm_base == '0);
      irq_md <= (new_md != '0) && (md_base == '0);
    end
  end
`else
  logic unused_coll;
  assign unused_coll = &{1'b0, pix_valid, rd_mm, rd_md};
  assign MM     = '0;
  assign MD     = '0;
  assign irq_mm = 1'b0;
  assign irq_md = 1'b0;
`endif
endmodule

// File: tb/tb_vicii_sprite_mux.sv
// Self-checking bench for vicii_sprite_mux: table-driven mux vectors plus
// collision/reset sequences; pixel expectations flow through a scoreboard queue.
module tb_vicii_sprite_mux;
  import vicii_pkg::*;

`ifdef VICII_SPRITE_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        clk, reset;
  logic [7:0]  spr_en;
  logic [31:0] spr_pix;
  logic [3:0]  bg_pix;
  logic        bg_fg;
  logic [7:0]  MDP;
  logic        pix_valid, rd_mm, rd_md;
  logic [3:0]  pixel;
  logic [7:0]  MM, MD;
  logic        irq_mm, irq_md;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  vicii_sprite_mux #(.NSPR(8)) dut (
    .clk(clk), .reset(reset), .spr_en(spr_en), .spr_pix(spr_pix),
    .bg_pix(bg_pix), .bg_fg(bg_fg), .MDP(MDP), .pix_valid(pix_valid),
    .rd_mm(rd_mm), .rd_md(rd_md), .pixel(pixel), .MM(MM), .MD(MD),
    .irq_mm(irq_mm), .irq_md(irq_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  en;
    logic [31:0] pix;
    logic [3:0]  bg;
    logic        fg;
    logic [7:0]  mdp;
    logic [3:0]  exp;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] en, input logic [31:0] pix, input logic [3:0] bg,
                       input logic fg, input logic [7:0] mdp, input logic pv,
                       input logic rmm, input logic rmd, input logic [3:0] exp);
    @(negedge clk);
    spr_en = en; spr_pix = pix; bg_pix = bg; bg_fg = fg; MDP = mdp;
    pix_valid = pv; rd_mm = rmm; rd_md = rmd;
    exp_q.push_back(exp);
  endtask

  task automatic settle(input string name);
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got pixel %h", name, pixel);
    end else begin
      e = exp_q.pop_front();
      chk(name, {4'h0, pixel}, {4'h0, e});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h06, 32'h0000_0520, 4'h1, 1'b0, 8'h00, 4'h2};
    vecs[1] = '{8'h01, 32'h0000_0009, 4'hE, 1'b1, 8'h01, 4'hE};
    vecs[2] = '{8'h01, 32'h0000_0009, 4'hE, 1'b0, 8'h01, 4'h9};
    vecs[3] = '{8'h03, 32'h0000_0049, 4'hC, 1'b1, 8'h01, 4'hC};
    vecs[4] = '{8'h03, 32'h0000_0049, 4'hC, 1'b1, 8'h02, 4'h9};
    vecs[5] = '{8'h00, 32'h8765_4321, 4'h5, 1'b1, 8'hFF, 4'h5};
    vecs[6] = '{8'h80, 32'hB000_0000, 4'h1, 1'b1, 8'h00, 4'hB};
    vecs[7] = '{8'h80, 32'hB000_0000, 4'h1, 1'b1, 8'h80, 4'h1};
    vecs[8] = '{8'hFF, 32'h8765_4321, 4'h0, 1'b0, 8'h00, 4'h1};
    vecs[9] = '{8'hFE, 32'h8765_4321, 4'h0, 1'b0, 8'h00, 4'h2};

    reset = 1'b1;
    spr_en = 8'hFF; spr_pix = 32'h7777_7777; bg_pix = 4'h3; bg_fg = 1'b1;
    MDP = 8'h00; pix_valid = 1'b1; rd_mm = 1'b0; rd_md = 1'b0;
    #3;
    chk("reset_pixel", {4'h0, pixel}, 8'h00);
    chk("reset_mm", MM, 8'h00);
    chk("reset_md", MD, 8'h00);
    chk("reset_irq_mm", {7'h0, irq_mm}, 8'h00);
    chk("reset_irq_md", {7'h0, irq_md}, 8'h00);
    @(posedge clk); #1;
    chk("reset_hold_pixel", {4'h0, pixel}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].en, vecs[i].pix, vecs[i].bg, vecs[i].fg, vecs[i].mdp,
            1'b0, 1'b0, 1'b0, vecs[i].exp);
      settle($sformatf("vec%0d_pixel", i));
    end
    chk("no_valid_mm", MM, 8'h00);
    chk("no_valid_md", MD, 8'h00);

    // sprite 0 and 7 overlap: first hit raises irq, repeat does not
    drive(8'h81, 32'h9000_0003, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h3);
    settle("mm1_pixel");
    chk("mm1_mm", MM, COLL ? 8'h81 : 8'h00);
    chk("mm1_irq", {7'h0, irq_mm}, {7'h0, COLL});
    chk("mm1_md", MD, 8'h00);
    drive(8'h81, 32'h9000_0003, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h3);
    settle("mm2_pixel");
    chk("mm2_mm", MM, COLL ? 8'h81 : 8'h00);
    chk("mm2_irq", {7'h0, irq_mm}, 8'h00);

    // read strobe with a fresh collision in the same cycle
    drive(8'h0C, 32'h0000_0A00, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'hA);
    #1;
    chk("rd_preclear_mm", MM, COLL ? 8'h81 : 8'h00);
    settle("rd_pixel");
    chk("rd_mm", MM, COLL ? 8'h0C : 8'h00);
    chk("rd_irq", {7'h0, irq_mm}, {7'h0, COLL});

    // sprite-data collision gated by pix_valid
    drive(8'h10, 32'h0006_0000, 4'h2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h6);
    settle("md0_pixel");
    chk("md0_md", MD, 8'h00);
    chk("md0_irq", {7'h0, irq_md}, 8'h00);
    chk("md0_irq_mm", {7'h0, irq_mm}, 8'h00);
    drive(8'h10, 32'h0006_0000, 4'h2, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'h6);
    settle("md1_pixel");
    chk("md1_md", MD, COLL ? 8'h10 : 8'h00);
    chk("md1_irq", {7'h0, irq_md}, {7'h0, COLL});
    chk("md1_mm", MM, COLL ? 8'h0C : 8'h00);

    // fill MM then reset between edges
    drive(8'hFF, 32'h0000_0007, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h7);
    settle("ff_pixel");
    chk("ff_mm", MM, COLL ? 8'hFF : 8'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_mm", MM, 8'h00);
    chk("midreset_md", MD, 8'h00);
    chk("midreset_pixel", {4'h0, pixel}, 8'h00);
    chk("midreset_irq", {6'h0, irq_mm, irq_md}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    drive(8'h00, 32'h0000_0007, 4'h3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h3);
    settle("post_reset_pixel");
    chk("post_reset_mm", MM, 8'h00);
    chk("post_reset_irq", {7'h0, irq_mm}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
